// File: rtl/r4acc_pkg.sv
// Shared constants and helpers for the product accumulator.
// Saturation bounds and sign extension are width-generic, up to 63-bit accumulators.
package r4acc_pkg;
    localparam int DEF_N       = 16;
    localparam int DEF_ACC_W   = 40;
    localparam int DEF_MAX_LEN = 256;

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // Sign-extend the low w bits of v to 64 bits.
    function automatic logic signed [63:0] sext(input logic [63:0] v, input int w);
        logic signed [63:0] t;
        t = signed'(v << (64 - w));
        return t >>> (64 - w);
    endfunction
endpackage

// File: rtl/r4acc_mac_accum_if.sv
// Product input stream and result output stream of the accumulator.
// The slave modport is the accumulator's view; master is the producer/consumer side.
interface r4acc_mac_accum_if
    import r4acc_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = $clog2(DEF_MAX_LEN + 1)
);
    logic             p_valid;
    logic             p_ready;
    logic [2*N-1:0]   p_data;
    logic             p_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output p_valid, p_data, p_last, out_ready,
        input  p_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  p_valid, p_data, p_last, out_ready,
        output p_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/r4acc_sat_add.sv
// Signed saturating add of a 2N-bit product into an ACC_W-bit accumulator.
// Combinational; no backpressure.
module r4acc_sat_add
    import r4acc_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [2*N-1:0]   addend,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);
    localparam logic signed [ACC_W:0] SMAX = (ACC_W + 1)'(sat_max(ACC_W));
    localparam logic signed [ACC_W:0] SMIN = (ACC_W + 1)'(sat_min(ACC_W));

    logic signed [ACC_W:0] acc_ext;
    logic signed [ACC_W:0] add_ext;
    logic signed [ACC_W:0] wide;

    // One guard bit is enough: the addend never exceeds the accumulator range.
    assign acc_ext = signed'((ACC_W + 1)'(sext(64'(acc), ACC_W)));
    assign add_ext = signed'((ACC_W + 1)'(sext(64'(addend), 2 * N)));
    assign wide    = acc_ext + add_ext;

    always_comb begin
        sum = wide[ACC_W-1:0];
        ovf = 1'b0;
        if (wide > SMAX) begin
            sum = SMAX[ACC_W-1:0];
            ovf = 1'b1;
        end else if (wide < SMIN) begin
            sum = SMIN[ACC_W-1:0];
            ovf = 1'b1;
        end
    end
endmodule

// File: rtl/r4acc_mac_accum.sv
// Registers multiplier products and accumulates them into a saturating dot-product sum.
// Latency: product handshaken in cycle t is added at end of t+1; result valid in t+2.
// Backpressure: while a result waits, the accumulator freezes and S1 buffers one product.
module r4acc_mac_accum
    import r4acc_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    r4acc_mac_accum_if.slave     bus
);
    logic [0:0]       state;
    logic             s1_valid;
    logic [2*N-1:0]   s1_data;
    logic             s1_last;
    logic             first;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_acc;

    logic [ACC_W-1:0] out_sum_r;
    logic [CNT_W-1:0] out_count_r;
    logic             out_ovf_r;
    logic             out_valid_r;

    logic             p_ready_int;
    logic             take;
    logic             drain;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] sat_sum;
    logic             sat_ovf;
    logic [CNT_W-1:0] cnt_new;
    logic             ovf_new;
    logic             done;

    assign p_ready_int = ~s1_valid | (state == ACCUM);
    assign take        = bus.p_valid & p_ready_int;
    assign drain       = (state == ACCUM) & s1_valid;

    // A new vector starts from zero rather than clearing acc on result handoff.
    assign base    = first ? '0 : acc;
    assign cnt_new = first ? CNT_W'(1) : cnt + CNT_W'(1);
    assign ovf_new = (~first & ovf_acc) | sat_ovf;
    assign done    = s1_last | (cnt_new == CNT_W'(MAX_LEN));

    r4acc_sat_add #(.N(N), .ACC_W(ACC_W)) u_sat_add (
        .acc    (base),
        .addend (s1_data),
        .sum    (sat_sum),
        .ovf    (sat_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_last  <= 1'b0;
        end else if (take) begin
            s1_valid <= 1'b1;
            s1_data  <= bus.p_data;
            s1_last  <= bus.p_last;
        end else if (drain) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            first       <= 1'b1;
            acc         <= '0;
            cnt         <= '0;
            ovf_acc     <= 1'b0;
            out_sum_r   <= '0;
            out_count_r <= '0;
            out_ovf_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (s1_valid) begin
                        acc     <= sat_sum;
                        cnt     <= cnt_new;
                        ovf_acc <= ovf_new;
                        first   <= 1'b0;
                        if (done) begin
                            out_sum_r   <= sat_sum;
                            out_count_r <= cnt_new;
                            out_ovf_r   <= ovf_new;
                            out_valid_r <= 1'b1;
                            state       <= HOLD;
                        end
                    end
                end
                default: begin
                    if (out_valid_r && bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        first       <= 1'b1;
                        state       <= ACCUM;
                    end
                end
            endcase
        end
    end

    assign bus.p_ready   = p_ready_int;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sum   = out_sum_r;
    assign bus.out_count = out_count_r;
    assign bus.out_ovf   = out_ovf_r;
endmodule

// File: tb/tb_r4acc_mac_accum.sv
// Scoreboard bench: three accumulator instances (default, ACC_W=33, MAX_LEN=4).
module tb_r4acc_mac_accum;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int hs_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    r4acc_mac_accum_if #(.N(16), .ACC_W(40), .CNT_W(9)) b0 ();
    r4acc_mac_accum_if #(.N(16), .ACC_W(33), .CNT_W(9)) b1 ();
    r4acc_mac_accum_if #(.N(16), .ACC_W(40), .CNT_W(3)) b2 ();

    r4acc_mac_accum #(.N(16), .ACC_W(40), .MAX_LEN(256)) d0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    r4acc_mac_accum #(.N(16), .ACC_W(33), .MAX_LEN(256)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    r4acc_mac_accum #(.N(16), .ACC_W(40), .MAX_LEN(4))   d2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    typedef struct {
        longint sum;
        int     cnt;
        bit     ovf;
        int     cyc;
    } res_t;

    res_t exp_q[$];
    res_t got_q[$];

    always @(negedge clk) begin
        if (b0.out_valid === 1'b1 && b0.out_ready === 1'b1)
            got_q.push_back('{longint'($signed(b0.out_sum)), int'(b0.out_count), b0.out_ovf, cyc});
        if (b1.out_valid === 1'b1 && b1.out_ready === 1'b1)
            got_q.push_back('{longint'($signed(b1.out_sum)), int'(b1.out_count), b1.out_ovf, cyc});
        if (b2.out_valid === 1'b1 && b2.out_ready === 1'b1)
            got_q.push_back('{longint'($signed(b2.out_sum)), int'(b2.out_count), b2.out_ovf, cyc});
    end

    task automatic drive(input int which, input logic v, input longint d, input logic l);
        case (which)
            0: begin b0.p_valid = v; b0.p_data = d[31:0]; b0.p_last = l; end
            1: begin b1.p_valid = v; b1.p_data = d[31:0]; b1.p_last = l; end
            default: begin b2.p_valid = v; b2.p_data = d[31:0]; b2.p_last = l; end
        endcase
    endtask

    task automatic send(input int which, input longint d, input bit last);
        bit hs = 1'b0;
        int n = 0;
        drive(which, 1'b1, d, last);
        while (!hs && n < 100) begin
            @(negedge clk);
            case (which)
                0: hs = b0.p_ready;
                1: hs = b1.p_ready;
                default: hs = b2.p_ready;
            endcase
            if (hs) hs_cyc = cyc;
            @(posedge clk); #1;
            n++;
        end
        drive(which, 1'b0, 0, 1'b0);
        if (!hs) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout dut%0d: p_ready stayed 0, required 1", which);
        end
    endtask

    task automatic wait_got(input int n);
        int k = 0;
        while (got_q.size() < n && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (b0.p_ready !== 1'b1) begin n_bad++; $display("FAIL reset_p_ready got %b, required 1", b0.p_ready); end
        n_cmp++;
        if (b0.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b, required 0", b0.out_valid); end
        n_cmp++;
        if (b0.out_sum !== 40'd0) begin n_bad++; $display("FAIL reset_out_sum got %h, required 0", b0.out_sum); end
        n_cmp++;
        if (b0.out_count !== 9'd0) begin n_bad++; $display("FAIL reset_out_count got %0d, required 0", b0.out_count); end
        n_cmp++;
        if (b0.out_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_out_ovf got %b, required 0", b0.out_ovf); end
    endtask

    task automatic test_basic();
        res_t e, g;
        int t_last;
        exp_q.push_back('{57, 3, 1'b0, 0});
        send(0, 100, 1'b0);
        send(0, -50, 1'b0);
        send(0, 7, 1'b1);
        t_last = hs_cyc;
        wait_got(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++; $display("FAIL basic_result missing, required sum=%0d", e.sum);
            end else begin
                g = got_q.pop_front();
                if (g.sum !== e.sum || g.cnt !== e.cnt || g.ovf !== e.ovf) begin
                    n_bad++;
                    $display("FAIL basic_result got sum=%0d cnt=%0d ovf=%0d, required sum=%0d cnt=%0d ovf=%0d",
                             g.sum, g.cnt, g.ovf, e.sum, e.cnt, e.ovf);
                end
                n_cmp++;
                if (g.cyc - t_last !== 2) begin
                    n_bad++; $display("FAIL basic_latency got %0d cycles, required 2", g.cyc - t_last);
                end
            end
        end
    endtask

    task automatic test_saturation();
        res_t e, g;
        exp_q.push_back('{64'sd4294967294, 4, 1'b1, 0});
        for (int i = 0; i < 3; i++) send(1, 64'h7FFF_FFFF, 1'b0);
        send(1, -1, 1'b1);
        wait_got(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++; $display("FAIL sat_result missing, required sum=%0d", e.sum);
            end else begin
                g = got_q.pop_front();
                if (g.sum !== e.sum || g.cnt !== e.cnt || g.ovf !== e.ovf) begin
                    n_bad++;
                    $display("FAIL sat_result got sum=%0d cnt=%0d ovf=%0d, required sum=%0d cnt=%0d ovf=%0d",
                             g.sum, g.cnt, g.ovf, e.sum, e.cnt, e.ovf);
                end
            end
        end
    endtask

    task automatic test_max_len();
        res_t e, g;
        exp_q.push_back('{4, 4, 1'b0, 0});
        exp_q.push_back('{4, 4, 1'b0, 0});
        exp_q.push_back('{1, 1, 1'b0, 0});
        for (int i = 0; i < 9; i++) send(2, 1, (i == 8));
        wait_got(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++; $display("FAIL maxlen_result missing, required sum=%0d", e.sum);
            end else begin
                g = got_q.pop_front();
                if (g.sum !== e.sum || g.cnt !== e.cnt || g.ovf !== e.ovf) begin
                    n_bad++;
                    $display("FAIL maxlen_result got sum=%0d cnt=%0d ovf=%0d, required sum=%0d cnt=%0d ovf=%0d",
                             g.sum, g.cnt, g.ovf, e.sum, e.cnt, e.ovf);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        res_t e, g;
        int k = 0;
        bit stable = 1'b1;
        b0.out_ready = 1'b0;
        exp_q.push_back('{3, 2, 1'b0, 0});
        exp_q.push_back('{10, 1, 1'b0, 0});
        send(0, 1, 1'b0);
        send(0, 2, 1'b1);
        while (b0.out_valid !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
        send(0, 10, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (b0.p_ready !== 1'b0) begin n_bad++; $display("FAIL bp_p_ready got %b, required 0", b0.p_ready); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (b0.out_valid !== 1'b1 || b0.out_sum !== 40'd3 || b0.out_count !== 9'd2 || b0.out_ovf !== 1'b0)
                stable = 1'b0;
        end
        n_cmp++;
        if (stable !== 1'b1) begin
            n_bad++; $display("FAIL bp_stable got valid=%b sum=%0d cnt=%0d, required valid=1 sum=3 cnt=2",
                              b0.out_valid, b0.out_sum, b0.out_count);
        end
        @(posedge clk); #1;
        b0.out_ready = 1'b1;
        wait_got(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++; $display("FAIL bp_result missing, required sum=%0d", e.sum);
            end else begin
                g = got_q.pop_front();
                if (g.sum !== e.sum || g.cnt !== e.cnt || g.ovf !== e.ovf) begin
                    n_bad++;
                    $display("FAIL bp_result got sum=%0d cnt=%0d ovf=%0d, required sum=%0d cnt=%0d ovf=%0d",
                             g.sum, g.cnt, g.ovf, e.sum, e.cnt, e.ovf);
                end
            end
        end
    endtask

    task automatic test_single();
        res_t e, g;
        int k = 0;
        exp_q.push_back('{-3, 1, 1'b0, 0});
        send(0, -3, 1'b1);
        while (b0.out_valid !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        n_cmp++;
        if (b0.out_sum !== 40'hFF_FFFF_FFFD) begin
            n_bad++; $display("FAIL single_bits got %h, required fffffffffd", b0.out_sum);
        end
        wait_got(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++; $display("FAIL single_result missing, required sum=%0d", e.sum);
            end else begin
                g = got_q.pop_front();
                if (g.sum !== e.sum || g.cnt !== e.cnt || g.ovf !== e.ovf) begin
                    n_bad++;
                    $display("FAIL single_result got sum=%0d cnt=%0d ovf=%0d, required sum=%0d cnt=%0d ovf=%0d",
                             g.sum, g.cnt, g.ovf, e.sum, e.cnt, e.ovf);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        res_t e, g;
        send(0, 5, 1'b0);
        send(0, 6, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (b0.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid got %b, required 0", b0.out_valid); end
        n_cmp++;
        if (b0.p_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_p_ready got %b, required 1", b0.p_ready); end
        @(posedge clk); #1;
        exp_q.push_back('{10, 2, 1'b0, 0});
        send(0, 5, 1'b0);
        send(0, 5, 1'b1);
        wait_got(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++; $display("FAIL rstmid_result missing, required sum=%0d", e.sum);
            end else begin
                g = got_q.pop_front();
                if (g.sum !== e.sum || g.cnt !== e.cnt || g.ovf !== e.ovf) begin
                    n_bad++;
                    $display("FAIL rstmid_result got sum=%0d cnt=%0d ovf=%0d, required sum=%0d cnt=%0d ovf=%0d",
                             g.sum, g.cnt, g.ovf, e.sum, e.cnt, e.ovf);
                end
            end
        end
    endtask

    initial begin
        drive(0, 1'b0, 0, 1'b0);
        drive(1, 1'b0, 0, 1'b0);
        drive(2, 1'b0, 0, 1'b0);
        b0.out_ready = 1'b1;
        b1.out_ready = 1'b1;
        b2.out_ready = 1'b1;
        rst_n = 1'b0;
        test_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_saturation();
        test_max_len();
        test_backpressure();
        test_single();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
